// File: rtl/stopwatch_pkg.sv
// Shared state encoding, widths and defaults for the stopwatch run-control block.
package stopwatch_pkg;

  localparam int BCD_DIGITS = 6;
  localparam int COUNT_W    = 4 * BCD_DIGITS;
  localparam int LAP_CNT_W  = 3;

  localparam logic [COUNT_W-1:0] MAX_COUNT_DEF = 24'h999999;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_LAP    = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_RECALL = 3'd4
  } sw_state_e;

endpackage

// File: rtl/sw_lap_buffer.sv
// Circular lap store with newest-first recall stepping; only built when SW_LAP_RECALL_EN is defined.
`ifdef SW_LAP_RECALL_EN
module sw_lap_buffer
  import stopwatch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 push,
  input  logic [COUNT_W-1:0]   push_data,
  input  logic                 rd_start,
  input  logic                 rd_step,
  output logic [COUNT_W-1:0]   rd_data,
  output logic [LAP_CNT_W-1:0] occupancy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [LAP_CNT_W-1:0] FULL_OCC = LAP_CNT_W'(DEPTH);

  logic [COUNT_W-1:0]   mem [DEPTH];
  logic [COUNT_W-1:0]   rd_data_q;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_idx_q, rd_idx_d;
  logic [LAP_CNT_W-1:0] occ_q, occ_d;
  logic [PTR_W-1:0]     newest, oldest;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? LAST_PTR : p - 1'b1;
  endfunction

  // Before the first wrap the writer started at slot 0, so the oldest entry is slot 0.
  assign newest = ptr_dec(wr_ptr_q);
  assign oldest = (occ_q == FULL_OCC) ? wr_ptr_q : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    rd_idx_d = rd_idx_q;
    if (clr) begin
      wr_ptr_d = '0;
      occ_d    = '0;
    end else if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
      if (occ_q != FULL_OCC) begin
        occ_d = occ_q + 1'b1;
      end
    end
    if (rd_start) begin
      rd_idx_d = newest;
    end else if (rd_step) begin
      rd_idx_d = (rd_idx_q == oldest) ? newest : ptr_dec(rd_idx_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      occ_q    <= '0;
      rd_idx_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  // Read with the next index so the entry lands in the same cycle the selection changes.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wr_ptr_q] <= push_data;
    end
    rd_data_q <= mem[rd_idx_d];
  end

  assign rd_data   = rd_data_q;
  assign occupancy = occ_q;

endmodule
`endif

// File: rtl/stopwatch_ctrl.sv
// Run-control sequencer for the 6-digit BCD stopwatch: key pulses to counter enable/clear and display select.
// Optional lap recall buffer enabled by defining SW_LAP_RECALL_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter logic [COUNT_W-1:0] MAX_COUNT = MAX_COUNT_DEF,
  parameter int                 LAP_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 key_ss,
  input  logic                 key_lap,
  input  logic                 key_clr,
  input  logic [COUNT_W-1:0]   count,
  output logic                 cnt_en,
  output logic                 cnt_clr,
  output logic [COUNT_W-1:0]   disp,
  output logic [2:0]           state,
  output logic                 ovf,
  output logic [LAP_CNT_W-1:0] lap_cnt
);

  sw_state_e            state_q, state_d;
  logic                 ovf_q, ovf_d;
  logic                 cnt_clr_q, cnt_clr_d;
  logic [COUNT_W-1:0]   hold_q, hold_d;

  logic                 at_full, running, full_stop;
  logic                 lap_push, recall_start, recall_step, buf_clr;
  logic                 recall_avail;
  logic [COUNT_W-1:0]   recall_data;
  logic [LAP_CNT_W-1:0] lap_cnt_w;

  assign at_full   = (count == MAX_COUNT);
  assign running   = (state_q == ST_RUN) || (state_q == ST_LAP);
  assign full_stop = running && tick && at_full;

  always_comb begin
    state_d      = state_q;
    ovf_d        = ovf_q;
    hold_d       = hold_q;
    cnt_clr_d    = 1'b0;
    lap_push     = 1'b0;
    recall_start = 1'b0;
    recall_step  = 1'b0;
    buf_clr      = 1'b0;
    if (key_clr) begin
      state_d   = ST_IDLE;
      ovf_d     = 1'b0;
      hold_d    = '0;
      cnt_clr_d = 1'b1;
      buf_clr   = 1'b1;
    end else if (full_stop) begin
      // Full scale outranks a coincident start/stop or lap key.
      state_d = ST_PAUSE;
      ovf_d   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (key_ss) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (key_ss) begin
            state_d = ST_PAUSE;
          end else if (key_lap) begin
            state_d  = ST_LAP;
            hold_d   = count;
            lap_push = 1'b1;
          end
        end
        ST_LAP: begin
          if (key_ss) begin
            state_d = ST_PAUSE;
          end else if (key_lap) begin
            state_d = ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (!ovf_q) begin
            if (key_ss) begin
              state_d = ST_RUN;
            end else if (key_lap && recall_avail) begin
              state_d      = ST_RECALL;
              recall_start = 1'b1;
            end
          end
        end
        ST_RECALL: begin
          if (key_ss) begin
            state_d = ST_PAUSE;
          end else if (key_lap) begin
            recall_step = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      ovf_q     <= 1'b0;
      cnt_clr_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      ovf_q     <= ovf_d;
      cnt_clr_q <= cnt_clr_d;
      hold_q    <= hold_d;
    end
  end

`ifdef SW_LAP_RECALL_EN
  sw_lap_buffer #(
    .DEPTH(LAP_DEPTH)
  ) u_lap_buffer (
    .clk      (clk),
    .rst_n    (rst),
    .clr      (buf_clr),
    .push     (lap_push),
    .push_data(count),
    .rd_start (recall_start),
    .rd_step  (recall_step),
    .rd_data  (recall_data),
    .occupancy(lap_cnt_w)
  );
  assign recall_avail = (lap_cnt_w != '0);
`else
  assign recall_data  = '0;
  assign lap_cnt_w    = '0;
  assign recall_avail = 1'b0;
  wire                 unused_buf_ctl   = &{1'b0, lap_push, recall_start, recall_step, buf_clr};
  wire [LAP_CNT_W-1:0] unused_lap_depth = LAP_CNT_W'(LAP_DEPTH);
`endif

  // Enable depends only on registered state and the live count, never on a key.
  assign cnt_en = running && !at_full;

  always_comb begin
    case (state_q)
      ST_LAP:    disp = hold_q;
      ST_RECALL: disp = recall_data;
      default:   disp = count;
    endcase
  end

  assign cnt_clr = cnt_clr_q;
  assign state   = state_q;
  assign ovf     = ovf_q;
  assign lap_cnt = lap_cnt_w;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed plus randomized bench for stopwatch_ctrl; two instances (default and full scale 5) against a behavioural model.
module tb_stopwatch_ctrl;

  localparam int S_IDLE = 0, S_RUN = 1, S_LAP = 2, S_PAUSE = 3, S_RECALL = 4;
  localparam int NLAP = 4;
`ifdef SW_LAP_RECALL_EN
  localparam bit RECALL_ON = 1'b1;
`else
  localparam bit RECALL_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0, key_ss = 1'b0, key_lap = 1'b0, key_clr = 1'b0;
  logic [23:0] cnt_in [2];
  logic        o_en   [2];
  logic        o_clr  [2];
  logic [23:0] o_disp [2];
  logic [2:0]  o_state[2];
  logic        o_ovf  [2];
  logic [2:0]  o_lapc [2];

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: one entry per instance; laps[0] is the newest capture.
  int          m_st   [2];
  bit          m_ovf  [2];
  bit          m_clr  [2];
  logic [23:0] m_hold [2];
  logic [23:0] m_cnt  [2];
  int          m_sel  [2];
  int          m_nlaps[2];
  logic [23:0] m_laps [2][NLAP];
  logic [23:0] m_max  [2];

  always #5 clk = ~clk;

  stopwatch_ctrl u_dut (
    .clk(clk), .rst(rst), .tick(tick), .key_ss(key_ss), .key_lap(key_lap), .key_clr(key_clr),
    .count(cnt_in[0]), .cnt_en(o_en[0]), .cnt_clr(o_clr[0]), .disp(o_disp[0]),
    .state(o_state[0]), .ovf(o_ovf[0]), .lap_cnt(o_lapc[0])
  );

  stopwatch_ctrl #(.MAX_COUNT(24'h000005), .LAP_DEPTH(4)) u_dut5 (
    .clk(clk), .rst(rst), .tick(tick), .key_ss(key_ss), .key_lap(key_lap), .key_clr(key_clr),
    .count(cnt_in[1]), .cnt_en(o_en[1]), .cnt_clr(o_clr[1]), .disp(o_disp[1]),
    .state(o_state[1]), .ovf(o_ovf[1]), .lap_cnt(o_lapc[1])
  );

  function automatic int bcd2int(input logic [23:0] b);
    int v = 0;
    for (int d = 5; d >= 0; d--) v = v * 10 + int'(b[d*4 +: 4]);
    return v;
  endfunction

  function automatic logic [23:0] int2bcd(input int v);
    logic [23:0] r = '0;
    int x = v;
    for (int d = 0; d < 6; d++) begin
      r[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic exp_en(input int i);
    return (m_st[i] == S_RUN || m_st[i] == S_LAP) && (m_cnt[i] != m_max[i]);
  endfunction

  function automatic logic [23:0] exp_disp(input int i);
    if (m_st[i] == S_LAP) return m_hold[i];
    if (m_st[i] == S_RECALL) return m_laps[i][m_sel[i]];
    return m_cnt[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = S_IDLE; m_ovf[i] = 0; m_clr[i] = 0; m_hold[i] = '0;
      m_sel[i] = 0; m_nlaps[i] = 0;
    end
  endtask

  // Advance instance i across one rising edge using the inputs present at that edge.
  task automatic model_edge(input int i);
    logic [23:0] c;
    bit run;
    c   = m_cnt[i];
    run = (m_st[i] == S_RUN || m_st[i] == S_LAP);
    if (m_clr[i]) m_cnt[i] = '0;
    else if (tick && run && c != m_max[i]) m_cnt[i] = int2bcd(bcd2int(c) + 1);
    m_clr[i] = key_clr;
    if (key_clr) begin
      m_st[i] = S_IDLE; m_ovf[i] = 0; m_hold[i] = '0; m_nlaps[i] = 0;
    end else if (run && tick && c == m_max[i]) begin
      m_st[i] = S_PAUSE; m_ovf[i] = 1;
    end else if (m_st[i] == S_IDLE) begin
      if (key_ss) m_st[i] = S_RUN;
    end else if (run) begin
      if (key_ss) m_st[i] = S_PAUSE;
      else if (key_lap && m_st[i] == S_RUN) begin
        m_st[i] = S_LAP;
        m_hold[i] = c;
        for (int k = NLAP - 1; k > 0; k--) m_laps[i][k] = m_laps[i][k-1];
        m_laps[i][0] = c;
        if (m_nlaps[i] < NLAP) m_nlaps[i]++;
      end else if (key_lap) m_st[i] = S_RUN;
    end else if (m_st[i] == S_PAUSE) begin
      if (!m_ovf[i]) begin
        if (key_ss) m_st[i] = S_RUN;
        else if (key_lap && RECALL_ON && m_nlaps[i] > 0) begin
          m_st[i] = S_RECALL; m_sel[i] = 0;
        end
      end
    end else if (m_st[i] == S_RECALL) begin
      if (key_ss) m_st[i] = S_PAUSE;
      else if (key_lap) m_sel[i] = (m_sel[i] + 1) % m_nlaps[i];
    end
  endtask

  task automatic cmp(input string tag, input int i, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s inst%0d observed=%0h expected=%0h t=%0t", tag, i, obs, want, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      cmp("state",   i, 32'(o_state[i]), 32'(m_st[i]));
      cmp("cnt_en",  i, 32'(o_en[i]),    32'(exp_en(i)));
      cmp("cnt_clr", i, 32'(o_clr[i]),   32'(m_clr[i]));
      cmp("disp",    i, 32'(o_disp[i]),  32'(exp_disp(i)));
      cmp("ovf",     i, 32'(o_ovf[i]),   32'(m_ovf[i]));
      cmp("lap_cnt", i, 32'(o_lapc[i]),  RECALL_ON ? 32'(m_nlaps[i]) : 32'd0);
    end
  endtask

  // Called at a falling edge: drive keys, cross one rising edge, then check at the next falling edge.
  task automatic step(input bit ss, input bit lp, input bit cl, input bit tk);
    key_ss = ss; key_lap = lp; key_clr = cl; tick = tk;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    key_ss = 0; key_lap = 0; key_clr = 0; tick = 0;
    cnt_in[0] = m_cnt[0];
    cnt_in[1] = m_cnt[1];
    @(negedge clk);
    check_all();
  endtask

  task automatic async_reset_check();
    #2 rst = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    check_all();
    rst = 1'b1;
  endtask

  logic [23:0] rec_exp [5];

  initial begin
    rec_exp = '{24'h50, 24'h40, 24'h30, 24'h20, 24'h50};
    m_max[0] = 24'h999999;
    m_max[1] = 24'h000005;
    m_cnt[0] = '0; m_cnt[1] = '0;
    cnt_in[0] = '0; cnt_in[1] = '0;
    for (int i = 0; i < 2; i++) for (int k = 0; k < NLAP; k++) m_laps[i][k] = '0;
    model_reset();
    #2 rst = 1'b0;
    #1 check_all();
    @(negedge clk);
    check_all();
    rst = 1'b1;

    // 1: start, 25 ticks, stop
    step(1, 0, 0, 0);
    repeat (25) step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    cmp("t1_state", 0, 32'(o_state[0]), S_PAUSE);
    cmp("t1_disp",  0, 32'(o_disp[0]), 32'h000025);

    // 2: lap freezes display at 42 while counting on
    step(1, 0, 0, 0);
    repeat (17) step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    repeat (10) step(0, 0, 0, 1);
    cmp("t2_frozen", 0, 32'(o_disp[0]), 32'h000042);
    cmp("t2_en",     0, 32'(o_en[0]), 32'd1);
    step(0, 1, 0, 0);
    cmp("t2_live", 0, 32'(o_disp[0]), 32'h000052);

    // 3: all three keys together while running
    step(1, 1, 1, 0);
    cmp("t3_clr",   0, 32'(o_clr[0]), 32'd1);
    cmp("t3_state", 0, 32'(o_state[0]), S_IDLE);
    step(0, 0, 0, 0);
    cmp("t3_clr_off", 0, 32'(o_clr[0]), 32'd0);
    cmp("t3_disp",    0, 32'(o_disp[0]), 32'h000000);
    cmp("t3_ovf",     1, 32'(o_ovf[1]), 32'd0);

    // 4: full scale 5 on the small instance
    step(1, 0, 0, 0);
    repeat (8) step(0, 0, 0, 1);
    cmp("t4_disp",  1, 32'(o_disp[1]), 32'h000005);
    cmp("t4_state", 1, 32'(o_state[1]), S_PAUSE);
    cmp("t4_ovf",   1, 32'(o_ovf[1]), 32'd1);
    step(1, 0, 0, 0);
    cmp("t4_ss_ign", 1, 32'(o_state[1]), S_PAUSE);
    step(0, 0, 1, 0);
    cmp("t4_cleared", 1, 32'(o_ovf[1]), 32'd0);

    // Full scale on the default instance via a preloaded counter
    step(0, 0, 0, 0);
    m_cnt[0] = 24'h999995;
    cnt_in[0] = m_cnt[0];
    step(1, 0, 0, 0);
    repeat (4) step(0, 0, 0, 1);
    cmp("fs_en_off", 0, 32'(o_en[0]), 32'd0);
    cmp("fs_disp",   0, 32'(o_disp[0]), 32'h999999);
    step(0, 0, 0, 1);
    cmp("fs_ovf", 0, 32'(o_ovf[0]), 32'd1);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    cmp("fs_stuck", 0, 32'(o_state[0]), S_PAUSE);

    // 5: five laps then recall
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      repeat (10) step(0, 0, 0, 1);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
    end
    step(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 0, 0);
`ifdef SW_LAP_RECALL_EN
      cmp("t5_recall", 0, 32'(o_disp[0]), 32'(rec_exp[k]));
`else
      cmp("t5_no_recall", 0, 32'(o_state[0]), S_PAUSE);
`endif
    end
`ifdef SW_LAP_RECALL_EN
    cmp("t5_lap_cnt", 0, 32'(o_lapc[0]), 32'd4);
`else
    cmp("t5_lap_cnt", 0, 32'(o_lapc[0]), 32'd0);
`endif
    step(1, 0, 0, 0);

    // Randomized key/tick traffic
    for (int n = 0; n < 500; n++) begin
      step($urandom_range(0, 6) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 40) == 0, $urandom_range(0, 1) == 1);
    end

    // 6: asynchronous reset mid-RUN and mid-LAP
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (5) step(0, 0, 0, 1);
    async_reset_check();
    step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 1);
    async_reset_check();
    repeat (3) step(0, 0, 0, 0);
    cmp("t6_state", 0, 32'(o_state[0]), S_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
